// File: rtl/mmu_pkg.sv
// Shared MMU definitions: PTE field positions, VPN slicing and walker state encoding.
package mmu_pkg;

  localparam int unsigned VPN_BITS      = 20;
  localparam int unsigned PPN_BITS      = 20;
  localparam int unsigned VPN_HALF_BITS = 10;
  localparam int unsigned PTE_BITS      = 32;
  localparam int unsigned ADDR_BITS     = 32;
  localparam int unsigned FLAG_BITS     = 5;

  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_R       = 1;
  localparam int unsigned PTE_W       = 2;
  localparam int unsigned PTE_X       = 3;
  localparam int unsigned PTE_U       = 4;
  localparam int unsigned PTE_PPN_LSB = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1_REQ,
    ST_L1_WAIT,
    ST_L2_REQ,
    ST_L2_WAIT,
    ST_RESP
  } ptw_state_e;

endpackage

// File: rtl/pte_check.sv
// Combinational PTE decode: pointer / leaf / fault and resulting PPN for one walk level.
// Superpage leaves at level 1 are accepted only when PTW_SUPERPAGE_EN is defined.
module pte_check
  import mmu_pkg::*;
(
  input  logic [PTE_BITS-1:0]      pte_i,
  input  logic                     level2_i,
  input  logic                     admin_i,
  input  logic [VPN_HALF_BITS-1:0] vpn0_i,
  output logic                     ptr_o,
  output logic                     fault_o,
  output logic [PPN_BITS-1:0]      ppn_o
);

`ifdef PTW_SUPERPAGE_EN
  localparam bit SP_EN = 1'b1;
`else
  localparam bit SP_EN = 1'b0;
`endif

  logic                                 v, r, w, x, u;
  logic                                 leaf, malformed, perm_bad, misaligned;
  logic [PPN_BITS-1:0]                  pte_ppn;
  logic [PTE_PPN_LSB-FLAG_BITS-1:0]     unused_rsv;

  assign v          = pte_i[PTE_V];
  assign r          = pte_i[PTE_R];
  assign w          = pte_i[PTE_W];
  assign x          = pte_i[PTE_X];
  assign u          = pte_i[PTE_U];
  assign pte_ppn    = pte_i[PTE_BITS-1:PTE_PPN_LSB];
  assign unused_rsv = pte_i[PTE_PPN_LSB-1:FLAG_BITS];

  assign leaf       = r | w | x;
  assign malformed  = !v || (w && !r);
  assign perm_bad   = (!admin_i && !u) || !x;
  assign misaligned = |pte_ppn[VPN_HALF_BITS-1:0];

  always_comb begin
    ptr_o   = 1'b0;
    fault_o = 1'b0;
    ppn_o   = pte_ppn;
    if (malformed) begin
      fault_o = 1'b1;
    end else if (!leaf) begin
      // A pointer is only legal at the first level
      if (level2_i) fault_o = 1'b1;
      else          ptr_o   = 1'b1;
    end else if (perm_bad) begin
      fault_o = 1'b1;
    end else if (!level2_i) begin
      if (!SP_EN || misaligned) fault_o = 1'b1;
      else ppn_o = {pte_ppn[PPN_BITS-1:VPN_HALF_BITS], vpn0_i};
    end
  end

endmodule

// File: rtl/ptw_walker.sv
// Two-level fetch-side page-table walker between the ITLB miss port and a PTE read port.
// Build option: PTW_SUPERPAGE_EN enables 4 MiB superpage leaves at level 1.
module ptw_walker
  import mmu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PPN_BITS-1:0]  ptbr_ppn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [VPN_BITS-1:0]  req_vpn,
  input  logic                 req_admin,
  input  logic                 flush,
  output logic                 resp_valid,
  output logic [PPN_BITS-1:0]  resp_ppn,
  output logic [FLAG_BITS-1:0] resp_flags,
  output logic                 resp_fault,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_rvalid,
  input  logic [PTE_BITS-1:0]  mem_rdata
);

  ptw_state_e                 state_q, state_d;
  logic [VPN_HALF_BITS-1:0]   vpn0_q, vpn0_d;
  logic                       admin_q, admin_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [PPN_BITS-1:0]        resp_ppn_q, resp_ppn_d;
  logic [FLAG_BITS-1:0]       resp_flags_q, resp_flags_d;
  logic                       resp_fault_q, resp_fault_d;

  logic                       l1_ptr, l1_fault, l2_ptr, l2_fault;
  logic [PPN_BITS-1:0]        l1_ppn, l2_ppn;
  logic                       lvl_fault;
  logic [PPN_BITS-1:0]        lvl_ppn;

  pte_check u_chk_l1 (
    .pte_i    (mem_rdata),
    .level2_i (1'b0),
    .admin_i  (admin_q),
    .vpn0_i   (vpn0_q),
    .ptr_o    (l1_ptr),
    .fault_o  (l1_fault),
    .ppn_o    (l1_ppn)
  );

  pte_check u_chk_l2 (
    .pte_i    (mem_rdata),
    .level2_i (1'b1),
    .admin_i  (admin_q),
    .vpn0_i   (vpn0_q),
    .ptr_o    (l2_ptr),
    .fault_o  (l2_fault),
    .ppn_o    (l2_ppn)
  );

  assign lvl_fault = (state_q == ST_L2_WAIT) ? (l2_fault || l2_ptr) : l1_fault;
  assign lvl_ppn   = (state_q == ST_L2_WAIT) ? l2_ppn : l1_ppn;

  assign req_ready     = (state_q == ST_IDLE) && !flush;
  assign resp_valid    = (state_q == ST_RESP) && !flush;
  assign mem_req_valid = (state_q == ST_L1_REQ) || (state_q == ST_L2_REQ);
  assign mem_addr      = mem_addr_q;
  assign resp_ppn      = resp_ppn_q;
  assign resp_flags    = resp_flags_q;
  assign resp_fault    = resp_fault_q;

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    vpn0_d       = vpn0_q;
    admin_d      = admin_q;
    flush_pend_d = flush_pend_q;
    mem_addr_d   = mem_addr_q;
    resp_ppn_d   = resp_ppn_q;
    resp_flags_d = resp_flags_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          vpn0_d     = req_vpn[VPN_HALF_BITS-1:0];
          admin_d    = req_admin;
          mem_addr_d = {ptbr_ppn, 12'b0}
                     + ADDR_BITS'({req_vpn[VPN_BITS-1:VPN_HALF_BITS], 2'b00});
          state_d    = ST_L1_REQ;
        end
      end
      ST_L1_REQ, ST_L2_REQ: begin
        // A read already handed to the arbiter must still be drained
        if (mem_req_ready) begin
          flush_pend_d = flush;
          state_d      = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L2_WAIT;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_L1_WAIT, ST_L2_WAIT: begin
        if (mem_rvalid) begin
          flush_pend_d = 1'b0;
          if (flush || flush_pend_q) begin
            state_d = ST_IDLE;
          end else if ((state_q == ST_L1_WAIT) && l1_ptr) begin
            mem_addr_d = {mem_rdata[PTE_BITS-1:PTE_PPN_LSB], 12'b0}
                       + ADDR_BITS'({vpn0_q, 2'b00});
            state_d    = ST_L2_REQ;
          end else begin
            resp_fault_d = lvl_fault;
            resp_ppn_d   = lvl_fault ? '0 : lvl_ppn;
            resp_flags_d = mem_rdata[FLAG_BITS-1:0];
            state_d      = ST_RESP;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vpn0_q       <= '0;
      admin_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      mem_addr_q   <= '0;
      resp_ppn_q   <= '0;
      resp_flags_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn0_q       <= vpn0_d;
      admin_q      <= admin_d;
      flush_pend_q <= flush_pend_d;
      mem_addr_q   <= mem_addr_d;
      resp_ppn_q   <= resp_ppn_d;
      resp_flags_q <= resp_flags_d;
      resp_fault_q <= resp_fault_d;
    end
  end

endmodule

// File: tb/tb_ptw_walker.sv
// Self-checking bench for ptw_walker: vector table plus flush, backpressure and reset sequences.
module tb_ptw_walker;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ptbr_ppn;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        req_admin;
  logic        flush;
  logic        resp_valid;
  logic [19:0] resp_ppn;
  logic [4:0]  resp_flags;
  logic        resp_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  ptw_walker dut (
    .clk           (clk),
    .rst           (rst),
    .ptbr_ppn      (ptbr_ppn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_vpn       (req_vpn),
    .req_admin     (req_admin),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ppn      (resp_ppn),
    .resp_flags    (resp_flags),
    .resp_fault    (resp_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] ptbr;
    logic [19:0] vpn;
    logic        admin;
    logic [31:0] l1_pte;
    logic [31:0] l2_pte;
    logic [31:0] l1_addr;
    logic [31:0] l2_addr;
    logic        l2_rd;
    logic [19:0] ppn;
    logic [4:0]  flags;
    logic        fault;
    int          lat;
  } vec_t;

  typedef struct {
    logic [19:0] ppn;
    logic [4:0]  flags;
    logic        fault;
    int          lat;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          resp_cnt = 0;
  int          stall_left = 0;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] m_l1_addr, m_l1_data, m_l2_addr, m_l2_data;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;
  logic        chk_hold = 1'b0;
  logic [19:0] hold_ppn = '0;
  vec_t        vecs[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [19:0] ptbr, logic [19:0] vpn, logic admin,
                              logic [31:0] l1, logic [31:0] l2, logic [31:0] a1,
                              logic [31:0] a2, logic l2rd, logic [19:0] ppn,
                              logic [4:0] flags, logic fault, int lat);
    vec_t v;
    v.ptbr = ptbr; v.vpn = vpn; v.admin = admin; v.l1_pte = l1; v.l2_pte = l2;
    v.l1_addr = a1; v.l2_addr = a2; v.l2_rd = l2rd; v.ppn = ppn; v.flags = flags;
    v.fault = fault; v.lat = lat;
    return v;
  endfunction

  // Memory responder: ready/stall control, address scoreboard, rvalid one cycle after accept
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (rd_pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_data;
      rd_pend    = 1'b0;
    end
    mem_req_ready = (stall_left == 0);
    if (mem_req_valid && mem_req_ready) begin
      if (addr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_read: got addr 0x%0h expected no read", mem_addr);
      end else begin
        check("mem_addr", mem_addr, addr_q.pop_front());
      end
      rd_pend = 1'b1;
      if (mem_addr == m_l1_addr)      rd_data = m_l1_data;
      else if (mem_addr == m_l2_addr) rd_data = m_l2_data;
      else                            rd_data = '0;
    end else if (mem_req_valid) begin
      stall_left--;
    end
  end

  // Response monitor: pop scoreboard on each pulse, then check the pulse ends and data holds
  always @(negedge clk) begin
    exp_t e;
    if (chk_hold) begin
      check("resp_pulse_len", 32'(resp_valid), 32'd0);
      check("resp_hold_ppn", 32'(resp_ppn), 32'(hold_ppn));
      chk_hold = 1'b0;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp: got ppn 0x%0h fault %0d expected no response", resp_ppn, resp_fault);
      end else begin
        e = exp_q.pop_front();
        check("resp_ppn", 32'(resp_ppn), 32'(e.ppn));
        check("resp_fault", 32'(resp_fault), 32'(e.fault));
        if (!e.fault) check("resp_flags", 32'(resp_flags), 32'(e.flags));
        check("resp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
      chk_hold = 1'b1;
      hold_ppn = resp_ppn;
    end
  end

  task automatic chk_reset();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_ppn", 32'(resp_ppn), 32'd0);
    check("rst_resp_flags", 32'(resp_flags), 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
  endtask

  // Entered at posedge+1; accept happens in the current cycle
  task automatic do_req(input logic [19:0] ptbr, input logic [19:0] vpn, input logic admin);
    ptbr_ppn = ptbr; req_vpn = vpn; req_admin = admin; req_valid = 1'b1;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic launch(input vec_t v, input int stall, input bit push_exp, input int lat_add);
    exp_t e;
    m_l1_addr = v.l1_addr; m_l1_data = v.l1_pte;
    m_l2_addr = v.l2_addr; m_l2_data = v.l2_pte;
    addr_q.push_back(v.l1_addr);
    if (v.l2_rd) addr_q.push_back(v.l2_addr);
    if (push_exp) begin
      e.ppn = v.ppn; e.flags = v.flags; e.fault = v.fault; e.lat = v.lat + lat_add;
      exp_q.push_back(e);
    end
    stall_left = stall;
    do_req(v.ptbr, v.vpn, v.admin);
  endtask

  task automatic wait_resp(input int n0);
    int t = 0;
    while (resp_cnt == n0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (resp_cnt == n0) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: got no response after %0d cycles expected one", t);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vpn = '0; req_admin = 1'b0;
    ptbr_ppn = '0; mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    m_l1_addr = '1; m_l1_data = '0; m_l2_addr = '1; m_l2_data = '0;

    vecs[0] = mk(20'h00010, 20'h00403, 1'b0, 32'h00020001, 32'h0005501F, 32'h00010004, 32'h0002000C, 1'b1, 20'h00055, 5'h1F, 1'b0, 5);
    vecs[1] = mk(20'h00010, 20'h00403, 1'b0, 32'h00000000, 32'h0005501F, 32'h00010004, 32'h0002000C, 1'b0, 20'h0,     5'h0,  1'b1, 3);
    vecs[2] = mk(20'h00010, 20'h00403, 1'b0, 32'h00020001, 32'h0005500F, 32'h00010004, 32'h0002000C, 1'b1, 20'h0,     5'h0,  1'b1, 5);
    vecs[3] = mk(20'h00010, 20'h00403, 1'b1, 32'h00020001, 32'h0005500F, 32'h00010004, 32'h0002000C, 1'b1, 20'h00055, 5'h0F, 1'b0, 5);
`ifdef PTW_SUPERPAGE_EN
    vecs[4] = mk(20'h00010, 20'h00403, 1'b1, 32'h0040000F, 32'h0,        32'h00010004, 32'h0002000C, 1'b0, 20'h00403, 5'h0F, 1'b0, 3);
`else
    vecs[4] = mk(20'h00010, 20'h00403, 1'b1, 32'h0040000F, 32'h0,        32'h00010004, 32'h0002000C, 1'b0, 20'h0,     5'h0,  1'b1, 3);
`endif
    vecs[5] = mk(20'h00010, 20'h00403, 1'b1, 32'h0040100F, 32'h0,        32'h00010004, 32'h0002000C, 1'b0, 20'h0,     5'h0,  1'b1, 3);
    vecs[6] = mk(20'h00010, 20'h00403, 1'b1, 32'h00020001, 32'h00055001, 32'h00010004, 32'h0002000C, 1'b1, 20'h0,     5'h0,  1'b1, 5);
    vecs[7] = mk(20'h00010, 20'h00403, 1'b1, 32'h00020001, 32'h00055013, 32'h00010004, 32'h0002000C, 1'b1, 20'h0,     5'h0,  1'b1, 5);
    vecs[8] = mk(20'h00010, 20'h00403, 1'b0, 32'h00020005, 32'h0005501F, 32'h00010004, 32'h0002000C, 1'b0, 20'h0,     5'h0,  1'b1, 3);
    vecs[9] = mk(20'hABCDE, 20'h12345, 1'b0, 32'h12345001, 32'h9876501B, 32'hABCDE120, 32'h12345D14, 1'b1, 20'h98765, 5'h1B, 1'b0, 5);

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: back-to-back walks, each request driven the cycle after the previous RESP
    for (int i = 0; i < 10; i++) begin
      n0 = resp_cnt;
      launch(vecs[i], 0, 1'b1, 0);
      wait_resp(n0);
      check("reads_done", 32'(addr_q.size()), 32'd0);
    end

    // Flush coincident with a request in IDLE: not accepted
    req_valid = 1'b1; req_vpn = 20'h00403; ptbr_ppn = 20'h00010; flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_no_accept", 32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure: four stalled cycles with a stable L1 address
    n0 = resp_cnt;
    launch(vecs[0], 4, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_req_valid", 32'(mem_req_valid), 32'd1);
      check("bp_addr_stable", mem_addr, 32'h00010004);
    end
    wait_resp(n0);
    check("bp_reads_done", 32'(addr_q.size()), 32'd0);

    // Flush in L2_WAIT: data returns, no response, idle next cycle
    n0 = resp_cnt;
    launch(vecs[0], 0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("flush_no_resp", 32'(resp_cnt), 32'(n0));
    check("flush_reads_done", 32'(addr_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset in L2_REQ; the outstanding read returns while idle
    n0 = resp_cnt;
    launch(vecs[0], 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset();
    repeat (4) @(negedge clk);
    check("rst_no_resp", 32'(resp_cnt), 32'(n0));
    check("rst_reads_done", 32'(addr_q.size()), 32'd0);
    @(posedge clk); #1;

    // Recovery after reset
    n0 = resp_cnt;
    launch(vecs[9], 0, 1'b1, 0);
    wait_resp(n0);
    check("recover_reads_done", 32'(addr_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
